spiker_run_ctrl: RTL and testbench

//  Run sequencer for the spiker core and its result-capture path. On a CSR start it:
//  - clears the core, then issues N timestep starts, waiting for each step to complete;
//  - after a settle delay, pulses the one-cycle sample strobe that latches the core's

---
 rtl/spiker_ctrl_pkg.sv | 20 ++
 rtl/spiker_ctrl_timer.sv | 29 ++
 rtl/spiker_run_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_spiker_run_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiker_ctrl_pkg.sv
// rtl/spiker_ctrl_pkg.sv - shared types for the spiker run sequencer
package spiker_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        STEP_START = 3'd2,
        STEP_WAIT  = 3'd3,
        SETTLE     = 3'd4,
        SAMPLE     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ZERO    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } err_e;

endpackage

// File: rtl/spiker_ctrl_timer.sv
// rtl/spiker_ctrl_timer.sv - loadable up-counter with enable and expiry compare
module spiker_ctrl_timer #(
    parameter int W = 20
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over counting so a new interval always restarts cleanly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expired_o = (cnt_q == limit_i);

endmodule

// File: rtl/spiker_run_ctrl.sv
// rtl/spiker_run_ctrl.sv - run sequencer: clear, N timesteps, settle, sample, status
module spiker_run_ctrl
    import spiker_ctrl_pkg::*;
#(
    parameter int STEP_W      = 16,
    parameter int TIMEOUT_W   = 20,
    parameter int TIMEOUT_CYC = 65535,
    parameter int SETTLE_CYC  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              clr_status_i,
    input  logic [STEP_W-1:0] n_steps_i,
    input  logic              core_done_i,
    output logic              core_clear_o,
    output logic              core_start_o,
    output logic              sample_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        err_o,
    output logic              irq_o,
    output logic [STEP_W-1:0] step_cnt_o
);

    // The timer is loaded with 1 so that its count equals cycles elapsed since
    // core_start_o (watchdog) or since entry into SETTLE (settle delay).
    localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT_CYC);
    localparam logic [TIMEOUT_W-1:0] ST_LIM = TIMEOUT_W'(SETTLE_CYC);
    localparam bit                   WD_EN  = (TIMEOUT_CYC != 0);

    state_e              state_q, state_d;
    err_e                err_q, err_val;
    logic [STEP_W-1:0]   n_lat_q;
    logic [STEP_W-1:0]   step_cnt_q;
    logic                done_q;
    logic                irq_q;
    logic                abort_clr_q;

    logic                start_acc;
    logic                step_inc;
    logic                set_done;
    logic                set_err;
    logic                abort_hit;
    logic                last_step;
    logic                tmr_load;
    logic                tmr_en;
    logic                tmr_expired;
    logic                wd_expired;
    logic [TIMEOUT_W-1:0] tmr_limit;

    assign last_step  = ((step_cnt_q + STEP_W'(1)) == n_lat_q);
    assign tmr_limit  = (state_q == SETTLE) ? ST_LIM : TO_LIM;
    assign wd_expired = WD_EN && tmr_expired;

    spiker_ctrl_timer #(
        .W(TIMEOUT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (TIMEOUT_W'(1)),
        .en_i       (tmr_en),
        .limit_i    (tmr_limit),
        .expired_o  (tmr_expired)
    );

    // Next-state and event decode; abort from any busy state overrides everything.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        step_inc  = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        err_val   = ERR_NONE;
        abort_hit = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (n_steps_i != '0) begin
                        start_acc = 1'b1;
                        state_d   = CLEAR;
                    end else begin
                        set_err = 1'b1;
                        err_val = ERR_ZERO;
                    end
                end
            end
            CLEAR: begin
                state_d = STEP_START;
            end
            STEP_START: begin
                tmr_load = 1'b1;
                state_d  = STEP_WAIT;
            end
            STEP_WAIT: begin
                tmr_en = 1'b1;
                if (core_done_i) begin
                    step_inc = 1'b1;
                    tmr_load = 1'b1;
                    if (last_step) begin
                        state_d = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
                    end else begin
                        state_d = STEP_START;
                    end
                end else if (wd_expired) begin
                    set_err = 1'b1;
                    err_val = ERR_TIMEOUT;
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                set_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_i && (state_q != IDLE)) begin
            state_d   = IDLE;
            abort_hit = 1'b1;
            step_inc  = 1'b0;
            set_done  = 1'b0;
            set_err   = 1'b1;
            err_val   = ERR_ABORT;
        end
    end

    // State register and run bookkeeping (latched step target, completed steps).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            n_lat_q     <= '0;
            step_cnt_q  <= '0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            abort_clr_q <= abort_hit;
            if (start_acc) begin
                n_lat_q    <= n_steps_i;
                step_cnt_q <= '0;
            end else if (step_inc) begin
                step_cnt_q <= step_cnt_q + STEP_W'(1);
            end
        end
    end

    // Sticky status and interrupt; a set event in the same cycle beats clr_status_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= 1'b0;
            err_q  <= ERR_NONE;
            irq_q  <= 1'b0;
        end else begin
            irq_q <= set_done | set_err;
            if (start_acc) begin
                done_q <= 1'b0;
                err_q  <= ERR_NONE;
            end else if (set_err) begin
                done_q <= 1'b0;
                err_q  <= err_val;
            end else if (set_done) begin
                done_q <= 1'b1;
            end else if (clr_status_i) begin
                done_q <= 1'b0;
                err_q  <= ERR_NONE;
            end
        end
    end

    // Core pulses are suppressed in a cycle where abort_i is taking the run down.
    assign core_clear_o = (state_q == CLEAR) || abort_clr_q;
    assign core_start_o = (state_q == STEP_START) && !abort_i;
    assign sample_o     = (state_q == SAMPLE) && !abort_i;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign irq_o        = irq_q;
    assign step_cnt_o   = step_cnt_q;

endmodule

// File: tb/tb_spiker_run_ctrl.sv
// tb/tb_spiker_run_ctrl.sv - self-checking bench for spiker_run_ctrl
module tb_spiker_run_ctrl;

    localparam int TO = 50;
    localparam int ST = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        clr_status_i = 1'b0;
    logic [15:0] n_steps_i = '0;
    logic        core_done_i = 1'b0;
    logic        core_clear_o, core_start_o, sample_o, busy_o, done_o, irq_o;
    logic [1:0]  err_o;
    logic [15:0] step_cnt_o;

    spiker_run_ctrl #(
        .STEP_W(16), .TIMEOUT_W(20), .TIMEOUT_CYC(TO), .SETTLE_CYC(ST)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .clr_status_i(clr_status_i), .n_steps_i(n_steps_i), .core_done_i(core_done_i),
        .core_clear_o(core_clear_o), .core_start_o(core_start_o), .sample_o(sample_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .irq_o(irq_o),
        .step_cnt_o(step_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // cycle k is the interval following the k-th rising edge
    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_chk = 0;
    int n_fail = 0;
    int m_steps = 0;

    int got_clear[$], got_start[$], got_sample[$], got_irq[$], got_busy[$];
    int resp_q[$];
    int done_at = -1;
    int run_gen = 0;
    int seen_gen = 0;
    int rd;
    logic busy_prev = 1'b0;

    typedef struct packed {
        int              n;
        logic [4:0][7:0] d;
        int              ab;
        int              xs;
        int              cl;
        int              e_err;
        int              e_done;
        int              e_steps;
    } vec_t;

    // core model: answers each core_start_o after the next queued delay (0 = never)
    always @(negedge clk_i) core_done_i = (cyc == done_at) && (seen_gen == run_gen);

    always @(negedge clk_i) begin
        #1;
        if (seen_gen != run_gen) begin
            seen_gen = run_gen;
            done_at  = -1;
        end
        if (rst_ni) begin
            if (core_clear_o) got_clear.push_back(cyc);
            if (core_start_o) begin
                got_start.push_back(cyc);
                if (resp_q.size() > 0) begin
                    rd = resp_q.pop_front();
                    if (rd > 0) done_at = cyc + rd;
                end
            end
            if (sample_o) got_sample.push_back(cyc);
            if (irq_o) got_irq.push_back(cyc);
            if (busy_o != busy_prev) got_busy.push_back(cyc);
        end
        busy_prev = busy_o;
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_list(input string nm, input int g[$], input int e[$]);
        chk({nm, " count"}, g.size(), e.size());
        for (int i = 0; i < g.size() && i < e.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), g[i], e[i]);
    endtask

    function automatic vec_t mk(input int n, input int d0, input int d1, input int d2,
                                input int d3, input int d4, input int ab, input int xs,
                                input int cl, input int e, input int dn, input int st);
        vec_t v;
        v.n = n;
        v.d[0] = 8'(d0); v.d[1] = 8'(d1); v.d[2] = 8'(d2); v.d[3] = 8'(d3); v.d[4] = 8'(d4);
        v.ab = ab; v.xs = xs; v.cl = cl;
        v.e_err = e; v.e_done = dn; v.e_steps = st;
        return v;
    endfunction

    task automatic clear_got();
        got_clear.delete(); got_start.delete(); got_sample.delete();
        got_irq.delete(); got_busy.delete();
    endtask

    // One run: timeline predicted from the run rules, then driven and compared.
    task automatic run_vec(input vec_t v, input bit use_tbl, input string nm);
        int S, t, end_t, dt, a, steps, err, done;
        int e_clear[$], e_start[$], e_sample[$], e_irq[$], e_busy[$], dts[$], tmp[$];
        run_gen++;
        resp_q.delete();
        for (int k = 0; k < 5; k++) resp_q.push_back(int'(v.d[k]));
        clear_got();
        @(negedge clk_i);
        S = cyc;
        err = 0; done = 0; end_t = S + 1; steps = m_steps;
        if (v.n == 0) begin
            err = 1;
        end else begin
            e_clear.push_back(S + 1);
            t = S + 2;
            end_t = -1;
            for (int k = 0; k < v.n && end_t < 0; k++) begin
                e_start.push_back(t);
                dt = int'(v.d[k]);
                if (dt == 0 || dt > TO) begin
                    end_t = t + TO + 1;
                    err = 2;
                end else begin
                    dts.push_back(t + dt);
                    if (k == v.n - 1) begin
                        e_sample.push_back(t + dt + ST + 1);
                        end_t = t + dt + ST + 2;
                        done = 1;
                    end else begin
                        t = t + dt + 1;
                    end
                end
            end
            a = S + v.ab;
            if (v.ab >= 1 && a <= end_t - 1) begin
                tmp = e_start;
                e_start.delete();
                foreach (tmp[i]) if (tmp[i] < a) e_start.push_back(tmp[i]);
                if (e_sample.size() > 0 && e_sample[0] >= a) e_sample.delete();
                e_clear.push_back(a + 1);
                end_t = a + 1;
                err = 3;
                done = 0;
            end
            steps = 0;
            foreach (dts[i]) if (dts[i] < end_t - 1) steps++;
            e_busy.push_back(S + 1);
            e_busy.push_back(end_t);
        end
        if (v.cl > 0 && S + v.cl >= end_t && S + v.cl <= end_t + 3) begin
            err = 0;
            done = 0;
        end
        e_irq.push_back(end_t);
        m_steps = steps;

        for (int c = S; c <= end_t + 3; c++) begin
            if (c != S) @(negedge clk_i);
            start_i      = (c == S) || (v.xs > 0 && c == S + v.xs);
            n_steps_i    = (c == S) ? 16'(v.n) : 16'd7;
            abort_i      = (v.ab >= 0 && c == S + v.ab);
            clr_status_i = (v.cl > 0 && c == S + v.cl);
        end
        #2;
        start_i = 0; abort_i = 0; clr_status_i = 0;

        chk_list({nm, " core_clear"}, got_clear, e_clear);
        chk_list({nm, " core_start"}, got_start, e_start);
        chk_list({nm, " sample"}, got_sample, e_sample);
        chk_list({nm, " irq"}, got_irq, e_irq);
        chk_list({nm, " busy_edges"}, got_busy, e_busy);
        if (use_tbl) begin
            chk({nm, " err"}, int'(err_o), v.e_err);
            chk({nm, " done"}, int'(done_o), v.e_done);
            chk({nm, " step_cnt"}, int'(step_cnt_o), v.e_steps);
        end else begin
            chk({nm, " err"}, int'(err_o), err);
            chk({nm, " done"}, int'(done_o), done);
            chk({nm, " step_cnt"}, int'(step_cnt_o), steps);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[12];
        vec_t v;
        int S;

        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst busy", int'(busy_o), 0);
        chk("rst done", int'(done_o), 0);
        chk("rst err", int'(err_o), 0);
        chk("rst step_cnt", int'(step_cnt_o), 0);
        chk("rst core_clear", int'(core_clear_o), 0);
        chk("rst core_start", int'(core_start_o), 0);
        chk("rst sample", int'(sample_o), 0);
        chk("rst irq", int'(irq_o), 0);

        //          n  d0 d1 d2 d3 d4  ab  xs  cl  err done steps
        tbl[0]  = mk(3, 4, 4, 4, 0, 0, -1, 0,  0,  0, 1, 3);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, -1, 0,  0,  1, 0, 3);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, -1, 0,  0,  2, 0, 0);
        tbl[3]  = mk(2, 50, 3, 0, 0, 0, -1, 0, 0,  0, 1, 2);
        tbl[4]  = mk(5, 6, 6, 6, 6, 6, 12, 0,  0,  3, 0, 1);
        tbl[5]  = mk(2, 5, 5, 0, 0, 0, -1, 4, 17,  0, 0, 2);
        tbl[6]  = mk(1, 3, 0, 0, 0, 0, -1, 0,  8,  0, 1, 1);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0,  0, 0,  0,  0, 1, 1);
        tbl[8]  = mk(1, 2, 0, 0, 0, 0,  7, 0,  0,  3, 0, 1);
        tbl[9]  = mk(2, 3, 2, 0, 0, 0,  1, 0,  0,  3, 0, 0);
        tbl[10] = mk(4, 1, 1, 1, 1, 0, -1, 0,  0,  0, 1, 4);
        tbl[11] = mk(1, 20, 0, 0, 0, 0, 2, 0,  0,  3, 0, 0);
        for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        // asynchronous reset while settling: everything drops, nothing fires afterwards
        run_gen++;
        resp_q.delete();
        resp_q.push_back(3);
        clear_got();
        @(negedge clk_i);
        S = cyc;
        start_i = 1'b1;
        n_steps_i = 16'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        #1;
        chk("rstmid busy_before", int'(busy_o), 1);
        chk("rstmid core_done_seen", int'(got_start.size()), 1);
        rst_ni = 1'b0;
        #1;
        chk("rstmid busy", int'(busy_o), 0);
        chk("rstmid done", int'(done_o), 0);
        chk("rstmid err", int'(err_o), 0);
        chk("rstmid step_cnt", int'(step_cnt_o), 0);
        chk("rstmid sample", int'(sample_o), 0);
        chk("rstmid core_clear", int'(core_clear_o), 0);
        chk("rstmid core_start", int'(core_start_o), 0);
        chk("rstmid irq", int'(irq_o), 0);
        m_steps = 0;
        repeat (2) @(negedge clk_i);
        run_gen++;
        rst_ni = 1'b1;
        clear_got();
        repeat (12) @(negedge clk_i);
        #2;
        chk("rstmid post sample", got_sample.size(), 0);
        chk("rstmid post start", got_start.size(), 0);
        chk("rstmid post clear", got_clear.size(), 0);
        chk("rstmid post irq", got_irq.size(), 0);
        chk("rstmid post busy", int'(busy_o), 0);

        for (int r = 0; r < 25; r++) begin
            v = mk(int'($urandom_range(0, 4)),
                   ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12)),
                   ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12)),
                   ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12)),
                   ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12)),
                   int'($urandom_range(1, 12)),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 25)) : -1,
                   0,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0,
                   0, 0, 0);
            run_vec(v, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
